// File: rtl/glyph_text_renderer_pkg.sv
// Shared geometry constants and the glyph table for the text-mode pixel stage.
// The font content is defined here so the ROM and any reference model read the same table.
package glyph_text_renderer_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int CELLS   = COLS * ROWS;
    localparam int ADDR_W  = 12;
    localparam int RGB_W   = 3;

    // One glyph line for a character code; bit 7 is the leftmost pixel.
    function automatic logic [7:0] font_row(input logic [7:0] code, input logic [3:0] line);
        logic [7:0] v;
        v = (code ^ {line, line}) * 8'd29 + 8'h5B;
        return v ^ {v[2:0], v[7:3]};
    endfunction

endpackage

// File: rtl/glyph_text_renderer_font_rom.sv
// 4096x8 glyph ROM addressed by {char, line}, one-cycle registered read.
// Contents come from the shared glyph table so every address is a constant.
module glyph_text_renderer_font_rom
    import glyph_text_renderer_pkg::*;
(
    input  logic        clk,
    input  logic [11:0] addr_i,
    output logic [7:0]  data_o
);

    logic [7:0] data_q;

    always_ff @(posedge clk) begin
        data_q <= font_row(addr_i[11:4], addr_i[3:0]);
    end

    assign data_o = data_q;

endmodule

// File: rtl/glyph_text_renderer.sv
// Text-mode pixel stage: 80x30 cells of 8x16 glyphs with a blinking underline cursor.
// Three register stages from counters to rgb; syncs and display enable ride along.
module glyph_text_renderer
    import glyph_text_renderer_pkg::*;
#(
    parameter int               COLS       = 80,
    parameter int               ROWS       = 30,
    parameter logic [RGB_W-1:0] FG_COLOR   = 3'b111,
    parameter logic [RGB_W-1:0] BG_COLOR   = 3'b001,
    parameter int               BLINK_LOG2 = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        counter_x,
    input  logic [8:0]        counter_y,
    input  logic              in_display,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              cursor_en,
    input  logic [6:0]        cursor_col,
    input  logic [4:0]        cursor_row,
    output logic [RGB_W-1:0]  rgb,
    output logic              h_sync_out,
    output logic              v_sync_out
);

    localparam int X_LO_W = $clog2(GLYPH_W);
    localparam int LINE_W = $clog2(GLYPH_H);

    // The shift-add cell address below is hard-wired for an 80-column grid.
    if (COLS * ROWS != CELLS || COLS != 80) begin : g_geometry_check
        $error("glyph_text_renderer: cell address math assumes an 80x30 grid");
    end

    function automatic logic [RGB_W-1:0] pixel_colour(input logic vld, input logic pix);
        if (!vld) return '0;
        return pix ? FG_COLOR : BG_COLOR;
    endfunction

    logic [6:0]              col_p0;
    logic [4:0]              row_p0;
    logic [LINE_W-1:0]       line_p0;
    logic [ADDR_W-1:0]       rd_addr_p0;
    logic                    hit_p0;
    logic                    wr_ok_p0;

    logic [7:0]              cbuf_mem [2**ADDR_W];
    logic [7:0]              char_p1_q;
    logic [LINE_W-1:0]       line_p1_q;
    logic [X_LO_W-1:0]       xlo_p1_q;
    logic [X_LO_W-1:0]       xlo_p2_q;
    logic [7:0]              glyph_p2;

    logic                    vld_p1_q, vld_p2_q;
    logic                    hit_p1_q, hit_p2_q;
    logic                    hs_p1_q, hs_p2_q, hs_p3_q;
    logic                    vs_p1_q, vs_p2_q, vs_p3_q;
    logic [RGB_W-1:0]        rgb_q, rgb_d;
    logic                    pix_p2;

    logic                    vs_prev_q;
    logic                    vs_fall;
    logic [BLINK_LOG2-1:0]   frame_q, frame_d;
    logic                    phase_q, phase_d;

    // ---- S0: cell address and cursor hit from the raw counters
    assign col_p0     = counter_x[9:3];
    assign row_p0     = counter_y[8:4];
    assign line_p0    = counter_y[LINE_W-1:0];
    assign rd_addr_p0 = {1'b0, row_p0, 6'b0} + {3'b0, row_p0, 4'b0} + {5'b0, col_p0};
    assign hit_p0     = cursor_en & (col_p0 == cursor_col) & (row_p0 == cursor_row)
                      & (line_p0 >= LINE_W'(GLYPH_H - 2));
    assign wr_ok_p0   = wr_en & (wr_addr < ADDR_W'(CELLS));

    // ---- S1: character buffer, read-first on a same-address write
    always_ff @(posedge clk) begin
        if (wr_ok_p0) begin
            cbuf_mem[wr_addr] <= wr_data;
        end
        char_p1_q <= cbuf_mem[rd_addr_p0];
    end

    always_ff @(posedge clk) begin
        line_p1_q <= line_p0;
        xlo_p1_q  <= counter_x[X_LO_W-1:0];
        xlo_p2_q  <= xlo_p1_q;
    end

    // ---- S2: glyph line lookup
    glyph_text_renderer_font_rom u_font_rom (
        .clk    (clk),
        .addr_i ({char_p1_q, line_p1_q}),
        .data_o (glyph_p2)
    );

    // ---- S3: pixel select, cursor inversion, colour
    always_comb begin
        pix_p2 = glyph_p2[X_LO_W'(GLYPH_W - 1) - xlo_p2_q] ^ (hit_p2_q & phase_q);
        rgb_d  = pixel_colour(vld_p2_q, pix_p2);
    end

    assign vs_fall = vs_prev_q & ~v_sync_in;

    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (vs_fall) begin
            frame_d = frame_q + 1'b1;
            if (frame_q == '1) begin
                phase_d = ~phase_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            hit_p1_q  <= 1'b0;
            hit_p2_q  <= 1'b0;
            hs_p1_q   <= 1'b1;
            hs_p2_q   <= 1'b1;
            hs_p3_q   <= 1'b1;
            vs_p1_q   <= 1'b1;
            vs_p2_q   <= 1'b1;
            vs_p3_q   <= 1'b1;
            rgb_q     <= '0;
            vs_prev_q <= 1'b1;
            frame_q   <= '0;
            phase_q   <= 1'b1;
        end else begin
            vld_p1_q  <= in_display;
            vld_p2_q  <= vld_p1_q;
            hit_p1_q  <= hit_p0;
            hit_p2_q  <= hit_p1_q;
            hs_p1_q   <= h_sync_in;
            hs_p2_q   <= hs_p1_q;
            hs_p3_q   <= hs_p2_q;
            vs_p1_q   <= v_sync_in;
            vs_p2_q   <= vs_p1_q;
            vs_p3_q   <= vs_p2_q;
            rgb_q     <= rgb_d;
            vs_prev_q <= v_sync_in;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
        end
    end

    assign rgb        = rgb_q;
    assign h_sync_out = hs_p3_q;
    assign v_sync_out = vs_p3_q;

endmodule

// File: tb/tb_glyph_text_renderer.sv
// Self-checking bench: a cell/font/blink reference model predicts rgb and syncs three clocks late.
module tb_glyph_text_renderer;
    import glyph_text_renderer_pkg::*;

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    localparam exp_t RST_OUT = '{rgb: 3'b000, hs: 1'b1, vs: 1'b1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  counter_x;
    logic [8:0]  counter_y;
    logic        in_display, h_sync_in, v_sync_in;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [2:0]  rgb;
    logic        h_sync_out, v_sync_out;

    logic [7:0]  cbuf_m [CELLS];
    int          falls_m;
    logic        vs_prev_m;
    exp_t        pipe_q [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    glyph_text_renderer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .in_display (in_display),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .rgb        (rgb),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out)
    );

    // Expected colour of screen pixel (x,y) from the cell contents and blink phase.
    function automatic logic [2:0] model_rgb(input int x, input int y, input logic disp);
        int         col, row, line;
        logic [7:0] bits;
        logic       pix;
        if (!disp) return 3'b000;
        col  = x / 8;
        row  = y / 16;
        line = y % 16;
        bits = font_row(cbuf_m[row * COLS + col], line[3:0]);
        pix  = bits[7 - (x % 8)];
        if (cursor_en && col == int'(cursor_col) && row == int'(cursor_row) && line >= 14
            && ((falls_m / 32) % 2 == 0))
            pix = ~pix;
        return pix ? 3'b111 : 3'b001;
    endfunction

    task automatic reset_model();
        pipe_q.delete();
        pipe_q.push_back(RST_OUT);
        pipe_q.push_back(RST_OUT);
        falls_m   = 0;
        vs_prev_m = 1'b1;
    endtask

    task automatic drive(input int x, input int y, input logic disp, input logic hs, input logic vs);
        counter_x  = 10'(x);
        counter_y  = 9'(y);
        in_display = disp;
        h_sync_in  = hs;
        v_sync_in  = vs;
    endtask

    // Advance one clock; returns what the outputs must show after this edge.
    task automatic tick(output exp_t got_exp);
        exp_t e;
        if (vs_prev_m && !v_sync_in) falls_m++;
        vs_prev_m = v_sync_in;
        e.rgb = model_rgb(int'(counter_x), int'(counter_y), in_display);
        e.hs  = h_sync_in;
        e.vs  = v_sync_in;
        pipe_q.push_back(e);
        if (wr_en && int'(wr_addr) < CELLS) cbuf_m[wr_addr] = wr_data;
        @(posedge clk);
        #1;
        got_exp = pipe_q.pop_front();
    endtask

    task automatic pulse_vsync(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            drive(700, 500, 1'b0, 1'b1, 1'b0);
            tick(e);
            drive(700, 500, 1'b0, 1'b1, 1'b1);
            tick(e);
        end
    endtask

    task automatic init_buffer();
        exp_t e;
        drive(700, 500, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < CELLS; i++) begin
            wr_en = 1'b1; wr_addr = 12'(i); wr_data = 8'h00;
            tick(e);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(i * 8, 0, 1'b1, i[0], 1'b1);
            @(posedge clk);
            #1;
            checks++;
            if (rgb !== 3'b000 || h_sync_out !== 1'b1 || v_sync_out !== 1'b1) begin
                errors++;
                $display("FAIL reset_hold: rgb=%b hs=%b vs=%b, expected 000 1 1", rgb, h_sync_out, v_sync_out);
            end
        end
        rst_n = 1'b1;
        reset_model();
        for (int i = 0; i < 8; i++) begin
            drive(700, 500, 1'b0, i[1], 1'b1);
            tick(e);
            checks++;
            if (rgb !== e.rgb || h_sync_out !== e.hs || v_sync_out !== e.vs) begin
                errors++;
                $display("FAIL reset_release: rgb=%b hs=%b vs=%b, expected %b %b %b",
                         rgb, h_sync_out, v_sync_out, e.rgb, e.hs, e.vs);
            end
        end
    endtask

    task automatic test_midline_reset();
        exp_t e;
        cursor_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(i * 8, 20, 1'b1, 1'b1, 1'b1);
            tick(e);
            checks++;
            if (rgb !== e.rgb) begin
                errors++;
                $display("FAIL pre_reset_pixel: rgb=%b expected %b", rgb, e.rgb);
            end
        end
        drive(48, 20, 1'b1, 1'b0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (rgb !== 3'b000 || h_sync_out !== 1'b1 || v_sync_out !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: rgb=%b hs=%b vs=%b, expected 000 1 1", rgb, h_sync_out, v_sync_out);
        end
        for (int i = 0; i < 2; i++) begin
            drive(56 + i * 8, 20, 1'b1, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            checks++;
            if (rgb !== 3'b000 || h_sync_out !== 1'b1 || v_sync_out !== 1'b1) begin
                errors++;
                $display("FAIL reset_midline_hold: rgb=%b hs=%b vs=%b", rgb, h_sync_out, v_sync_out);
            end
        end
        rst_n = 1'b1;
        reset_model();
        for (int i = 0; i < 24; i++) begin
            drive($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b1);
            tick(e);
            checks++;
            if (rgb !== e.rgb || h_sync_out !== e.hs) begin
                errors++;
                $display("FAIL post_reset_follow: rgb=%b hs=%b expected %b %b", rgb, h_sync_out, e.rgb, e.hs);
            end
        end
    endtask

    task automatic test_glyph();
        exp_t e;
        drive(700, 500, 1'b0, 1'b1, 1'b1);
        wr_en = 1'b1; wr_addr = 12'd0; wr_data = 8'h41;
        tick(e);
        wr_en = 1'b0;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 8; x++) begin
                drive(x, y, 1'b1, 1'b1, 1'b1);
                tick(e);
                checks++;
                if (rgb !== e.rgb) begin
                    errors++;
                    $display("FAIL glyph_A x=%0d y=%0d: rgb=%b expected %b", x, y, rgb, e.rgb);
                end
            end
        end
    endtask

    task automatic test_addr_math();
        exp_t e;
        int   cx [3] = '{79, 78, 79};
        int   cy [3] = '{29, 29, 28};
        drive(700, 500, 1'b0, 1'b1, 1'b1);
        wr_en = 1'b1; wr_addr = 12'd2399; wr_data = 8'h58;
        tick(e);
        wr_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int y = 0; y < 16; y++) begin
                for (int x = 0; x < 8; x++) begin
                    drive(cx[c] * 8 + x, cy[c] * 16 + y, 1'b1, 1'b1, 1'b1);
                    tick(e);
                    checks++;
                    if (rgb !== e.rgb) begin
                        errors++;
                        $display("FAIL addr_cell(%0d,%0d) px=%0d,%0d: rgb=%b expected %b",
                                 cx[c], cy[c], x, y, rgb, e.rgb);
                    end
                end
            end
        end
    endtask

    task automatic test_sync();
        exp_t e;
        for (int x = 640; x < 800; x++) begin
            drive(x, 490, 1'b0, !(x >= 657 && x <= 751), 1'b1);
            tick(e);
            checks++;
            if (h_sync_out !== e.hs || rgb !== e.rgb) begin
                errors++;
                $display("FAIL hsync_align x=%0d: hs=%b rgb=%b expected %b %b", x, h_sync_out, rgb, e.hs, e.rgb);
            end
        end
        for (int i = 0; i < 12; i++) begin
            drive(700, 480 + i, 1'b0, 1'b1, !(i >= 3 && i <= 5));
            tick(e);
            checks++;
            if (v_sync_out !== e.vs) begin
                errors++;
                $display("FAIL vsync_align step=%0d: vs=%b expected %b", i, v_sync_out, e.vs);
            end
        end
    endtask

    task automatic test_write_bounds();
        exp_t e;
        drive(700, 500, 1'b0, 1'b1, 1'b1);
        wr_en = 1'b1; wr_addr = 12'd2400; wr_data = 8'hFF;
        tick(e);
        wr_addr = 12'd4095;
        tick(e);
        wr_en = 1'b0;
        // cell 352 is where a truncated 11-bit index of 2400 would land
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 8; x++) begin
                drive(256 + x, 64 + y, 1'b1, 1'b1, 1'b1);
                tick(e);
                checks++;
                if (rgb !== e.rgb) begin
                    errors++;
                    $display("FAIL oob_write_cell352 px=%0d,%0d: rgb=%b expected %b", x, y, rgb, e.rgb);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(80, 0, 1'b1, 1'b1, 1'b1);
            wr_en = (i == 0); wr_addr = 12'd10; wr_data = 8'h03;
            tick(e);
            checks++;
            if (rgb !== e.rgb) begin
                errors++;
                $display("FAIL read_first step=%0d: rgb=%b expected %b", i, rgb, e.rgb);
            end
        end
        wr_en = 1'b0;
        for (int y = 0; y < 16; y++) begin
            drive(81, y, 1'b1, 1'b1, 1'b1);
            tick(e);
            checks++;
            if (rgb !== e.rgb) begin
                errors++;
                $display("FAIL new_char_cell10 y=%0d: rgb=%b expected %b", y, rgb, e.rgb);
            end
        end
    endtask

    task automatic test_cursor_blink();
        exp_t e;
        int   pulses [6] = '{0, 31, 1, 31, 1, 0};
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
        drive(700, 500, 1'b0, 1'b1, 1'b1);
        wr_en = 1'b1; wr_addr = 12'd165; wr_data = 8'($urandom_range(1, 255));
        tick(e);
        wr_en = 1'b0;
        cursor_col = 7'd5; cursor_row = 5'd2;
        for (int p = 0; p < 6; p++) begin
            pulse_vsync(pulses[p]);
            cursor_en = (p != 5);
            for (int y = 44; y < 48; y++) begin
                for (int x = 40; x < 48; x++) begin
                    drive(x, y, 1'b1, 1'b1, 1'b1);
                    tick(e);
                    checks++;
                    if (rgb !== e.rgb) begin
                        errors++;
                        $display("FAIL cursor_blink frames=%0d px=%0d,%0d: rgb=%b expected %b",
                                 falls_m, x, y, rgb, e.rgb);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        int   x, y;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                cursor_col = 7'($urandom_range(0, 79));
                cursor_row = 5'($urandom_range(0, 29));
            end
            x = $urandom_range(0, 799);
            y = $urandom_range(0, 511);
            drive(x, y, (x < 640 && y < 480) && ($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 1)), 1'b1);
            cursor_en = 1'($urandom_range(0, 1));
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = 12'($urandom_range(0, 4095));
            wr_data   = 8'($urandom_range(0, 255));
            tick(e);
            checks++;
            if (rgb !== e.rgb || h_sync_out !== e.hs || v_sync_out !== e.vs) begin
                errors++;
                $display("FAIL random step=%0d: rgb=%b hs=%b vs=%b expected %b %b %b",
                         i, rgb, h_sync_out, v_sync_out, e.rgb, e.hs, e.vs);
            end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        cursor_en  = 1'b0;
        cursor_col = '0;
        cursor_row = '0;
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        test_reset();
        init_buffer();
        test_midline_reset();
        test_glyph();
        test_addr_math();
        test_sync();
        test_write_bounds();
        test_cursor_blink();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
